// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing to the draw stages.
// frame_cnt exists only with VGA_TIMING_FRAME_CNT_EN.
interface vga_timing_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (
    output hcount, vcount,
    output hsync, vsync,
    output hblnk, vblnk,
    output frame_start,
    output frame_cnt
  );

  modport slave (
    input hcount, vcount,
    input hsync, vsync,
    input hblnk, vblnk,
    input frame_start,
    input frame_cnt
  );
`else
  modport master (
    output hcount, vcount,
    output hsync, vsync,
    output hblnk, vblnk,
    output frame_start
  );

  modport slave (
    input hcount, vcount,
    input hsync, vsync,
    input hblnk, vblnk,
    input frame_start
  );
`endif
endinterface

// File: rtl/vga_timing.sv
// Free-running XGA raster generator; all outputs registered.
// VGA_TIMING_FRAME_CNT_EN adds the completed-frame counter.
module vga_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_TOTAL  = 1344,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_TOTAL  = 806
) (
  input  logic        pclk,
  input  logic        rst,
  vga_timing_if.master vga
);

  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLK = 11'(H_ACTIVE);
  localparam logic [10:0] V_BLK = 11'(V_ACTIVE);
  localparam logic [10:0] HS_ON = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF =
    11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF =
    11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hc, vc;
  logic [10:0] hc_n, vc_n;
  logic        h_end, v_end;
  logic        hs, vs, hb, vb, fs;

  // Flags are derived from the next counter pair so they
  // land in the same register stage as the counters.
  always_comb begin
    h_end = (hc == H_MAX);
    v_end = (vc == V_MAX);
    hc_n  = h_end ? 11'd0 : hc + 11'd1;
    vc_n  = vc;
    if (h_end)
      vc_n = v_end ? 11'd0 : vc + 11'd1;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
      hs <= 1'b0;
      vs <= 1'b0;
      hb <= 1'b0;
      vb <= 1'b0;
      fs <= 1'b0;
    end else begin
      hc <= hc_n;
      vc <= vc_n;
      hs <= (hc_n >= HS_ON) && (hc_n < HS_OFF);
      vs <= (vc_n >= VS_ON) && (vc_n < VS_OFF);
      hb <= (hc_n >= H_BLK);
      vb <= (vc_n >= V_BLK);
      fs <= h_end && v_end;
    end
  end

  assign vga.hcount      = hc;
  assign vga.vcount      = vc;
  assign vga.hsync       = hs;
  assign vga.vsync       = vs;
  assign vga.hblnk       = hb;
  assign vga.vblnk       = vb;
  assign vga.frame_start = fs;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      fc <= '0;
    else if (fs)
      fc <= fc + 16'd1;
  end

  assign vga.frame_cnt = fc;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: XGA instance for line timing, a small
// raster instance for frame-level and reset corner cases.
module tb_vga_timing;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 pclk = ~pclk;

  vga_timing_if if_x ();
  vga_timing_if if_s ();

  vga_timing u_x (
    .pclk (pclk),
    .rst  (rst),
    .vga  (if_x)
  );

  vga_timing #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_TOTAL (24),
    .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_TOTAL (10)
  ) u_s (
    .pclk (pclk),
    .rst  (rst),
    .vga  (if_s)
  );

  // {h, v, hsync, vsync, hblnk, vblnk, frame_start}
  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } exp_t;

  typedef struct {
    int   k;
    exp_t e;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mkv(int k, int h, int v,
                               logic [4:0] f);
    vec_t r;
    r.k = k;
    r.e = {11'(h), 11'(v), f};
    return r;
  endfunction

  function automatic exp_t model(int k, int ha, int hf,
      int hw, int ht, int va, int vf, int vw, int vt);
    exp_t r;
    int h, v;
    h = k % ht;
    v = (k / ht) % vt;
    r.h  = 11'(h);
    r.v  = 11'(v);
    r.hs = (h >= ha + hf) && (h < ha + hf + hw);
    r.vs = (v >= va + vf) && (v < va + vf + vw);
    r.hb = (h >= ha);
    r.vb = (v >= va);
    r.fs = (k > 0) && (h == 0) && (v == 0);
    return r;
  endfunction

  function automatic exp_t got_s();
    return {if_s.hcount, if_s.vcount, if_s.hsync,
            if_s.vsync, if_s.hblnk, if_s.vblnk,
            if_s.frame_start};
  endfunction

  function automatic exp_t got_x();
    return {if_x.hcount, if_x.vcount, if_x.hsync,
            if_x.vsync, if_x.hblnk, if_x.vblnk,
            if_x.frame_start};
  endfunction

  task automatic chk(string nm, int k, exp_t a, exp_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s k=%0d got=%h want=%h",
               nm, k, a, e);
    end
  endtask

  task automatic chk_int(string nm, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, a, e);
    end
  endtask

  task automatic release_rst();
    @(negedge pclk);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int n_fs;
    int fs_k[$];
    exp_t z;
    z = '0;

    tbl[0]  = mkv(1,   1,  0, 5'b00000);
    tbl[1]  = mkv(15,  15, 0, 5'b00000);
    tbl[2]  = mkv(16,  16, 0, 5'b00100);
    tbl[3]  = mkv(18,  18, 0, 5'b10100);
    tbl[4]  = mkv(20,  20, 0, 5'b10100);
    tbl[5]  = mkv(21,  21, 0, 5'b00100);
    tbl[6]  = mkv(23,  23, 0, 5'b00100);
    tbl[7]  = mkv(24,  0,  1, 5'b00000);
    tbl[8]  = mkv(144, 0,  6, 5'b00010);
    tbl[9]  = mkv(168, 0,  7, 5'b01010);
    tbl[10] = mkv(186, 18, 7, 5'b11110);
    tbl[11] = mkv(216, 0,  9, 5'b00010);
    tbl[12] = mkv(239, 23, 9, 5'b00110);
    tbl[13] = mkv(240, 0,  0, 5'b00001);
    tbl[14] = mkv(241, 1,  0, 5'b00000);

    // Reset held from time 0
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_s", 0, got_s(), z);
    chk("rst_x", 0, got_x(), z);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk_int("rst_fc", int'(if_s.frame_cnt), 0);
`endif

    // Table-driven pass on the small raster
    release_rst();
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        @(posedge pclk);
        k++;
      end
      #1;
      chk("tbl", k, got_s(), tbl[i].e);
    end

    // Asynchronous reset at an arbitrary point, 5 cycles
    @(posedge pclk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_s", 0, got_s(), z);
    chk("rst_async_x", 0, got_x(), z);
    repeat (5) @(posedge pclk);
    #1;
    chk("rst_hold_s", 0, got_s(), z);
    chk("rst_hold_x", 0, got_x(), z);

    // Full XGA line plus 5+ small frames, cycle by cycle
    release_rst();
    n_fs = 0;
    for (int c = 1; c <= 1344; c++) begin
      @(posedge pclk);
      #1;
      chk("xga_line", c, got_x(),
          model(c, 1024, 24, 136, 1344, 768, 3, 6, 806));
      chk("small_run", c, got_s(),
          model(c, 16, 2, 3, 24, 6, 1, 2, 10));
      if (c <= 719 && if_s.frame_start) begin
        n_fs++;
        fs_k.push_back(c);
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (c == 719)
        chk_int("frame_cnt", int'(if_s.frame_cnt), 2);
`endif
    end
    chk_int("fs_count", n_fs, 2);
    if (fs_k.size() == 2) begin
      chk_int("fs_first", fs_k[0], 240);
      chk_int("fs_period", fs_k[1] - fs_k[0], 240);
    end else begin
      chk_int("fs_pulses_seen", fs_k.size(), 2);
    end

    // Reset mid-sync: small raster at h=19, v=7
    rst = 1'b1;
    #20;
    release_rst();
    repeat (187) @(posedge pclk);
    #1;
    chk("pre_midsync", 187, got_s(),
        mkv(0, 19, 7, 5'b11110).e);
    #2;
    rst = 1'b1;
    #1;
    chk("midsync_clr_s", 0, got_s(), z);
    chk("midsync_clr_x", 0, got_x(), z);
    repeat (2) @(posedge pclk);
    release_rst();
    @(posedge pclk);
    #1;
    chk("resume_s", 1, got_s(), mkv(0, 1, 0, 5'b0).e);
    chk("resume_x", 1, got_x(), mkv(0, 1, 0, 5'b0).e);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
